// File: rtl/bits_unpack_ctrl.sv
// Read-side controller for the bitstream word FIFO: refills a 64-bit MSB-first
// bit buffer one word at a time and serves 0..15-bit right-justified fields.
module bits_unpack_ctrl #(
  parameter int WORD_W = 32,
  parameter int BUF_W  = 64,
  parameter int LEN_W  = 4,
  parameter int OUT_W  = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_pop,
  input  logic              reqin,
  input  logic [LEN_W-1:0]  reqlen,
  input  logic              flush,
  output logic              reqbusy,
  output logic              pushout,
  output logic [LEN_W-1:0]  lenout,
  output logic [OUT_W-1:0]  dataout,
  output logic              ovr_err,
  output logic [6:0]        bit_count
);

  localparam int CNT_W = 7;

  typedef enum logic [1:0] {R_IDLE, R_POP, R_CAP} rstate_t;
  typedef enum logic {Q_IDLE, Q_PEND} qstate_t;

  // Handshake: reqin is a one-cycle strobe taken only while reqbusy=0; each
  // accepted request yields exactly one pushout strobe unless flushed or reset.

  rstate_t            r_state;
  qstate_t            q_state;
  logic [BUF_W-1:0]   bit_buf;
  logic [LEN_W-1:0]   pend_len;

  logic               serve;
  logic [LEN_W-1:0]   serve_len;
  logic [CNT_W-1:0]   consume_len;
  logic [CNT_W-1:0]   remaining;
  logic [OUT_W-1:0]   top_bits;
  logic [OUT_W-1:0]   field;
  logic [BUF_W-1:0]   shifted;
  logic [BUF_W-1:0]   appended;
  logic               capture;

  // Serving only looks at the pre-append bit_count, so a word captured on
  // the same edge can never satisfy the request being served.
  always_comb begin
    serve     = 1'b0;
    serve_len = pend_len;
    if (!flush) begin
      if (q_state == Q_PEND) begin
        serve_len = pend_len;
        serve     = (CNT_W'(pend_len) <= bit_count);
      end else if (reqin) begin
        serve_len = reqlen;
        serve     = (CNT_W'(reqlen) <= bit_count);
      end
    end
    consume_len = serve ? CNT_W'(serve_len) : '0;
    remaining   = bit_count - consume_len;
    top_bits    = bit_buf[BUF_W-1 -: OUT_W];
    field       = top_bits >> (OUT_W - int'(serve_len));
    shifted     = bit_buf << consume_len;
    appended    = shifted | ({fifo_data, {(BUF_W-WORD_W){1'b0}}} >> remaining);
    capture     = (r_state == R_CAP) && !flush;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= R_IDLE;
      q_state   <= Q_IDLE;
      bit_buf   <= '0;
      bit_count <= '0;
      pend_len  <= '0;
      fifo_pop  <= 1'b0;
      reqbusy   <= 1'b0;
      pushout   <= 1'b0;
      lenout    <= '0;
      dataout   <= '0;
      ovr_err   <= 1'b0;
    end else begin
      pushout <= serve;
      if (serve) begin
        lenout  <= serve_len;
        dataout <= field;
      end
      if (reqin && q_state == Q_PEND) ovr_err <= 1'b1;

      if (flush) begin
        q_state <= Q_IDLE;
        reqbusy <= 1'b0;
      end else begin
        case (q_state)
          Q_IDLE: if (reqin && !serve) begin
            q_state  <= Q_PEND;
            pend_len <= reqlen;
            reqbusy  <= 1'b1;
          end
          Q_PEND: if (serve) begin
            q_state <= Q_IDLE;
            reqbusy <= 1'b0;
          end
          default: q_state <= Q_IDLE;
        endcase
      end

      if (flush) begin
        bit_buf   <= '0;
        bit_count <= '0;
      end else if (capture) begin
        bit_buf   <= appended;
        bit_count <= remaining + CNT_W'(WORD_W);
      end else begin
        bit_buf   <= shifted;
        bit_count <= remaining;
      end

      // A pop already issued still completes through R_CAP even under flush.
      case (r_state)
        R_IDLE: if (bit_count <= CNT_W'(WORD_W) && !fifo_empty && !flush) begin
          r_state  <= R_POP;
          fifo_pop <= 1'b1;
        end
        R_POP: begin
          r_state  <= R_CAP;
          fifo_pop <= 1'b0;
        end
        R_CAP: r_state <= R_IDLE;
        default: begin
          r_state  <= R_IDLE;
          fifo_pop <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bits_unpack_ctrl.md
Name:
bits_unpack_ctrl

Overview:
Read-side controller for the 32-bit word FIFO in the bitstream path. It pops 32-bit words from the FIFO and holds them in a 64-bit bit buffer. It serves variable-length bit requests of 0–15 bits, MSB-first, returning each as a right-justified field. It sits between the FIFO read port and the downstream bit consumer. It owns all FIFO read sequencing and the consumer-side request/response handshake.

Parameters:
WORD_W, 32, FIFO word width
BUF_W, 64, bit buffer capacity, must be 2*WORD_W
LEN_W, 4, request length field width
OUT_W, 15, dataout width, must be 2**LEN_W-1

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
fifo_data  in  WORD_W  FIFO data_out
fifo_empty  in  1  FIFO empty flag
fifo_pop  out  1  FIFO rd_en, registered
reqin  in  1  request strobe, one cycle
reqlen  in  LEN_W  requested bit count, 0..15
flush  in  1  synchronous clear of buffer and pending request
reqbusy  out  1  request pending, not yet served
pushout  out  1  one-cycle result strobe
lenout  out  LEN_W  length of returned field
dataout  out  OUT_W  returned bits, right-justified
ovr_err  out  1  sticky: reqin arrived while reqbusy=1
bit_count  out  7  valid bits in buffer, 0..64

Behaviour:
- Reset: all outputs are 0; buffer is cleared; bit_count is 0; both FSMs are in IDLE. Reset is asynchronous and active-high; the clock and reset ports are named clock and reset.
- Bit order: the MSB of each FIFO word is the first stream bit. Buffer valid bits are left-aligned: buf[63] is the oldest bit.
- Refill FSM:
  - States: R_IDLE, R_POP, R_CAP.
  - R_IDLE→R_POP when bit_count<=32 and fifo_empty=0 and flush=0. fifo_pop is high for exactly one cycle, while in R_POP.
  - R_POP→R_CAP unconditionally.
  - In R_CAP, fifo_data is valid. At the end of R_CAP the word is appended at buffer position (bit_count_after_consume), and the FSM returns to R_IDLE.
  - At most one pop is outstanding at any time.
  - The FIFO is never popped when fifo_empty=1.
- Request FSM:
  - States: Q_IDLE, Q_PEND.
  - reqin is accepted only in Q_IDLE; reqlen is latched on acceptance.
  - If bit_count>=len at the accepting edge, the request is served at that edge and Q_IDLE is kept. Otherwise the FSM enters Q_PEND with reqbusy=1.
  - In Q_PEND, the request is served at the first edge where bit_count>=len, then the FSM returns to Q_IDLE.
  - reqin while reqbusy=1 is dropped and sets ovr_err=1 until reset.
- Serve:
  - At the serving edge: pushout=1 for the next cycle; lenout=len; dataout[len-1:0]=oldest len bits, with dataout[len-1] the oldest; upper bits are 0.
  - Buffer shifts left by len; bit_count -= len.
  - Minimum latency: pushout is high in the cycle after the reqin cycle.
  - pushout is 0 in every other cycle; lenout and dataout hold their last values.
- reqlen=0: served immediately with pushout=1, lenout=0, dataout=0; no bits are consumed.
- Same-edge consume and append: new bit_count = bit_count - len + 32. The appended word lands directly after the remaining bits. Serving uses only pre-append bits; a request is never satisfied by the word being captured at that edge.
- Boundaries:
  - bit_count==len is served and leaves the buffer empty.
  - bit_count never exceeds 64, because a refill requires <=32 bits at pop time and bits only decrease until capture.
- flush:
  - At the next edge: buffer and bit_count→0; a pending request is discarded without pushout; reqbusy→0.
  - A word captured in R_CAP on the flush edge is discarded.
  - An R_POP in progress completes to R_CAP, and its word is kept. The FIFO read has already happened.
  - ovr_err is unaffected by flush.
- Reset mid-operation: immediate return to the reset state. An outstanding fetched word is lost. No pushout is generated.

Test Plan:
- FIFO holds 0xA5000000; reqin with reqlen=4 after the refill → next cycle pushout=1, lenout=4, dataout=0x000A, bit_count=28.
- FIFO holds 0xF0F0F0F0, 0x12345678; requests of 15, 15, 6 bits → dataout=0x7878, then 0x3C3C, then 0x0001 (crosses the word boundary).
- FIFO empty; reqin reqlen=8 → reqbusy=1, no pushout; push 0xC3000000 → pushout in the cycle after capture, dataout=0x00C3, reqbusy=0.
- reqin reqlen=15 pending with bit_count=0; a second reqin → ovr_err=1 stays set; the first request is still served once data arrives; flush does not clear ovr_err.
- bit_count=10 with a request pending for 12 and a capture in the same cycle; assert flush → bit_count=0, reqbusy=0, no pushout; the next pop proceeds normally.
- Assert reset asynchronously during R_CAP with reqbusy=1 → all outputs are 0 immediately; no pushout after reset release.
